// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM states and the two-word opcode encodings (lds/sts, jmp/call).
// Pure declarations; is_two_word is combinational and is also reused by decode.
package fetch_pkg;

   typedef enum logic [1:0] {WARM, FETCH1, FETCH2} fetch_state_t;

   localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
   localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;
   localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
   localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

   function automatic logic is_two_word(input logic [15:0] w);
      return ((w & LDS_STS_MASK) == LDS_STS_MATCH) ||
             ((w & JMP_CALL_MASK) == JMP_CALL_MATCH);
   endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Flags a first instruction word that needs a second word; combinational, no handshake.
module instr_len_decode
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] i_word,
   output logic                  o_two_word
);

   assign o_two_word = is_two_word(i_word[15:0]);

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: PC -> ROM, one/two-word assembly, valid/ready to decode; holds everything while decode stalls.
// Optional FETCH_SKIP_EN adds a skip input that silently drops the next assembled instruction.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
`ifdef FETCH_SKIP_EN
   input  logic                  skip,
`endif
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_ext,
   output logic                  instr_two,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

   localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

   fetch_state_t          r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
   logic                  r_valid, w_valid_nxt;
   logic [DATA_WIDTH-1:0] r_instr, w_instr_nxt;
   logic [DATA_WIDTH-1:0] r_ext, w_ext_nxt;
   logic                  r_two, w_two_nxt;
   logic [ADDR_WIDTH-1:0] r_ipc, w_ipc_nxt;
   logic [DATA_WIDTH-1:0] r_w1, w_w1_nxt;
   logic [ADDR_WIDTH-1:0] r_w1_pc, w_w1_pc_nxt;
   logic                  w_two;
   logic                  w_free;
   logic                  w_drop;

   instr_len_decode #(.DATA_WIDTH(DATA_WIDTH)) u_len (
      .i_word     (rom_data),
      .o_two_word (w_two)
   );

   assign w_free = !r_valid || instr_ready;

`ifdef FETCH_SKIP_EN
   logic r_skip, w_skip_nxt;

   assign w_drop = r_skip;

   // Flag clears once the dropped instruction has been fully consumed from ROM.
   always_comb begin
      w_skip_nxt = r_skip | skip;
      if (branch_en)
         w_skip_nxt = 1'b0;
      else if (r_skip && w_free &&
               ((r_state == FETCH1 && !w_two) || r_state == FETCH2))
         w_skip_nxt = skip;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_skip <= 1'b0;
      else        r_skip <= w_skip_nxt;
   end
`else
   assign w_drop = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid;
      w_instr_nxt = r_instr;
      w_ext_nxt   = r_ext;
      w_two_nxt   = r_two;
      w_ipc_nxt   = r_ipc;
      w_w1_nxt    = r_w1;
      w_w1_pc_nxt = r_w1_pc;
      if (branch_en) begin
         w_pc_nxt    = branch_addr;
         w_state_nxt = FETCH1;
         w_valid_nxt = 1'b0;
      end else begin
         case (r_state)
            WARM: w_state_nxt = FETCH1;
            FETCH1: if (w_free) begin
               w_pc_nxt = r_pc + 1'b1;
               if (w_two) begin
                  w_w1_nxt    = rom_data;
                  w_w1_pc_nxt = r_pc;
                  w_state_nxt = FETCH2;
                  w_valid_nxt = 1'b0;
               end else if (w_drop) begin
                  w_valid_nxt = 1'b0;
               end else begin
                  w_instr_nxt = rom_data;
                  w_ext_nxt   = '0;
                  w_two_nxt   = 1'b0;
                  w_ipc_nxt   = r_pc;
                  w_valid_nxt = 1'b1;
               end
            end
            FETCH2: if (w_free) begin
               w_pc_nxt    = r_pc + 1'b1;
               w_state_nxt = FETCH1;
               if (w_drop) begin
                  w_valid_nxt = 1'b0;
               end else begin
                  w_instr_nxt = r_w1;
                  w_ext_nxt   = rom_data;
                  w_two_nxt   = 1'b1;
                  w_ipc_nxt   = r_w1_pc;
                  w_valid_nxt = 1'b1;
               end
            end
            default: w_state_nxt = WARM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WARM;
         r_pc    <= RST_PC;
         r_valid <= 1'b0;
         r_instr <= '0;
         r_ext   <= '0;
         r_two   <= 1'b0;
         r_ipc   <= '0;
         r_w1    <= '0;
         r_w1_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_valid <= w_valid_nxt;
         r_instr <= w_instr_nxt;
         r_ext   <= w_ext_nxt;
         r_two   <= w_two_nxt;
         r_ipc   <= w_ipc_nxt;
         r_w1    <= w_w1_nxt;
         r_w1_pc <= w_w1_pc_nxt;
      end
   end

   assign rom_addr    = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_ext   = r_ext;
   assign instr_two   = r_two;
   assign instr_pc    = r_ipc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: directed ROM image, stalls, branches, wrap and mid-run reset.
module tb_instr_fetch;

   typedef struct {
      logic [15:0] i;
      logic [15:0] e;
      logic        t;
      logic [7:0]  pc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rom_addr;
   logic [15:0] rom_q;
   logic        branch_en;
   logic [7:0]  branch_addr;
   logic        skip;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_ext;
   logic        instr_two;
   logic [7:0]  instr_pc;

   logic [15:0] rom [256];
   exp_t        q [$];
   int          n_chk = 0;
   int          n_err = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rom_addr    (rom_addr),
      .rom_data    (rom_q),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
`ifdef FETCH_SKIP_EN
      .skip        (skip),
`endif
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_ext   (instr_ext),
      .instr_two   (instr_two),
      .instr_pc    (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM registers the addressed word on the falling edge
   always @(negedge clk) rom_q <= rom[rom_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] e, input logic t, input logic [7:0] p);
      exp_t x;
      x.i = i; x.e = e; x.t = t; x.pc = p;
      q.push_back(x);
   endtask

   task automatic chk_cleared(input string nm);
      chk({nm, "_valid"}, 32'(instr_valid), 32'd0);
      chk({nm, "_instr"}, 32'(instr), 32'd0);
      chk({nm, "_ext"}, 32'(instr_ext), 32'd0);
      chk({nm, "_two"}, 32'(instr_two), 32'd0);
      chk({nm, "_pc"}, 32'(instr_pc), 32'd0);
      chk({nm, "_rom_addr"}, 32'(rom_addr), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
         n_chk++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got instr=%h pc=%h, none expected", instr, instr_pc);
         end else begin
            x = q.pop_front();
            if ({instr, instr_ext, instr_two, instr_pc} !== {x.i, x.e, x.t, x.pc}) begin
               n_err++;
               $display("FAIL handshake: got instr=%h ext=%h two=%b pc=%h expected instr=%h ext=%h two=%b pc=%h",
                        instr, instr_ext, instr_two, instr_pc, x.i, x.e, x.t, x.pc);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 256; k++) rom[k] = 16'h0100 + 16'(k);
      rom[8'h00] = 16'h0000;
      rom[8'h01] = 16'h9411;
      rom[8'h02] = 16'h0C12;
      rom[8'h03] = 16'h940C;
      rom[8'h04] = 16'h0040;
      rom[8'h05] = 16'h0C55;
      rom[8'h06] = 16'h0C66;
      rom[8'h10] = 16'h0C10;
      rom[8'h20] = 16'h9200;
      rom[8'h21] = 16'h1234;
      rom[8'hFF] = 16'h9200;
      rst_n = 1'b0; instr_ready = 1'b1; branch_en = 1'b0; branch_addr = 8'h00; skip = 1'b0;

      #12;
      chk_cleared("reset");

      push(16'h0000, 16'h0000, 1'b0, 8'h00);
      push(16'h9411, 16'h0000, 1'b0, 8'h01);
      push(16'h0C12, 16'h0000, 1'b0, 8'h02);
      push(16'h940C, 16'h0040, 1'b1, 8'h03);
      push(16'h0C55, 16'h0000, 1'b0, 8'h05);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick(); chk("warm_bubble", 32'(instr_valid), 32'd0);
      tick(); chk("first_valid", 32'(instr_valid), 32'd1);
      chk("first_pc", 32'(instr_pc), 32'd0);
      tick(); tick();
      tick(); chk("two_word_gap", 32'(instr_valid), 32'd0);
      tick(); chk("jmp_two", 32'(instr_two), 32'd1);
      tick(); chk("after_jmp_pc", 32'(instr_pc), 32'h05);

      instr_ready = 1'b0;
      repeat (3) begin
         tick();
         chk("stall_pc", 32'(instr_pc), 32'h05);
         chk("stall_instr", 32'(instr), 32'h0C55);
         chk("stall_rom_addr", 32'(rom_addr), 32'h06);
      end
      instr_ready = 1'b1;
      push(16'h0C66, 16'h0000, 1'b0, 8'h06);
      tick(); chk("resume_pc", 32'(instr_pc), 32'h06);

      branch_en = 1'b1; branch_addr = 8'h20;
      tick(); branch_en = 1'b0;
      chk("br1_valid", 32'(instr_valid), 32'd0);
      chk("br1_rom_addr", 32'(rom_addr), 32'h20);
      tick(); chk("f2_valid", 32'(instr_valid), 32'd0);
      chk("f2_rom_addr", 32'(rom_addr), 32'h21);
      branch_en = 1'b1; branch_addr = 8'h10;
      tick(); branch_en = 1'b0;
      chk("br2_valid", 32'(instr_valid), 32'd0);
      chk("br2_rom_addr", 32'(rom_addr), 32'h10);
      push(16'h0C10, 16'h0000, 1'b0, 8'h10);
      tick(); chk("br2_target_pc", 32'(instr_pc), 32'h10);
      chk("br2_target_valid", 32'(instr_valid), 32'd1);

      rom[8'h00] = 16'h0060;
      push(16'h9200, 16'h0060, 1'b1, 8'hFF);
      push(16'h9411, 16'h0000, 1'b0, 8'h01);
      push(16'h0C12, 16'h0000, 1'b0, 8'h02);
      branch_en = 1'b1; branch_addr = 8'hFF;
      tick(); branch_en = 1'b0;
      chk("br3_valid", 32'(instr_valid), 32'd0);
      chk("br3_rom_addr", 32'(rom_addr), 32'hFF);
      tick(); chk("wrap_rom_addr", 32'(rom_addr), 32'h00);
      tick(); chk("wrap_next_addr", 32'(rom_addr), 32'h01);
      chk("wrap_pc", 32'(instr_pc), 32'hFF);
      tick(); tick();
      tick(); chk("pre_reset_f2", 32'(instr_valid), 32'd0);

      rst_n = 1'b0;
      #1;
      chk_cleared("mid_reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(16'h0060, 16'h0000, 1'b0, 8'h00);
      tick(); chk("rewarm_bubble", 32'(instr_valid), 32'd0);
      tick(); chk("rewarm_valid", 32'(instr_valid), 32'd1);
      chk("rewarm_pc", 32'(instr_pc), 32'h00);
`ifdef FETCH_SKIP_EN
      push(16'h9411, 16'h0000, 1'b0, 8'h01);
      push(16'h0C12, 16'h0000, 1'b0, 8'h02);
      push(16'h0C55, 16'h0000, 1'b0, 8'h05);
      tick(); skip = 1'b1;
      tick(); skip = 1'b0;
      tick(); chk("skip_f2_valid", 32'(instr_valid), 32'd0);
      tick(); chk("skip_drop_valid", 32'(instr_valid), 32'd0);
      tick(); chk("skip_next_pc", 32'(instr_pc), 32'h05);
      tick();
`else
      tick();
`endif
      instr_ready = 1'b0;
      repeat (3) tick();
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
